// File: rtl/pll_reset_seq.sv
// PLL lock qualification and core reset sequencer with pixel clock-enable generation.
// Holds game logic in reset until the PLL has been locked for STABLE_CYCLES clocks.
module pll_reset_seq #(
  parameter int unsigned STABLE_CYCLES = 4096,
  parameter int unsigned CE_DIV        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       ext_reset_req,
  output logic       core_reset,
  output logic       ce_pix,
  output logic       ce_pix_n,
  output logic [1:0] status
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CE_DIV / 2 - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'b00,
    ST_STABLE    = 2'b01,
    ST_RUN       = 2'b10
  } state_e;

  logic [1:0]       lock_sync_q, lock_sync_d;
  logic [1:0]       ext_sync_q, ext_sync_d;
  logic             locked_s, ext_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             core_reset_q, core_reset_d;
  logic             ce_pix_q, ce_pix_d;
  logic             ce_pix_n_q, ce_pix_n_d;

  // Two-flop synchronizers; bit 1 is the settled sample.
  always_comb begin
    lock_sync_d = {lock_sync_q[0], pll_locked};
    ext_sync_d  = {ext_sync_q[0], ext_reset_req};
  end

  assign locked_s = lock_sync_q[1];
  assign ext_s    = ext_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sync_q <= '0;
      ext_sync_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      lock_sync_q <= lock_sync_d;
      ext_sync_q  <= ext_sync_d;
    end
  end

  // State register, including the registered outputs that must change in
  // the same cycle as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      div_q        <= '0;
      core_reset_q <= 1'b1;
      ce_pix_q     <= 1'b0;
      ce_pix_n_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      core_reset_q <= core_reset_d;
      ce_pix_q     <= ce_pix_d;
      ce_pix_n_q   <= ce_pix_n_d;
    end
  end

  // Next-state logic: lock loss beats a reset request, which beats the
  // terminal count.
  always_comb begin
    // NOTE: defaults assigned up front so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = ST_STABLE;
      end

      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (ext_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        cnt_d = '0;
        if (!locked_s)  state_d = ST_WAIT_LOCK;
        else if (ext_s) state_d = ST_STABLE;
      end

      default: begin
        // Unreachable code 11 behaves exactly like WAIT_LOCK.
        cnt_d   = '0;
        state_d = locked_s ? ST_STABLE : ST_WAIT_LOCK;
      end
    endcase

    // Divider restarts at 0 on every entry into RUN and idles at 0 elsewhere.
    div_d = '0;
    if (state_d == ST_RUN && state_q == ST_RUN) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  // Output logic: registered outputs are decoded from the upcoming state so
  // they align with the state register; status is decoded from the current one.
  always_comb begin
    core_reset_d = (state_d != ST_RUN);
    ce_pix_d     = (state_d == ST_RUN) && (div_d == DIV_LAST);
    ce_pix_n_d   = (state_d == ST_RUN) && (div_d == DIV_HALF);

    case (state_q)
      ST_STABLE: status = 2'b01;
      ST_RUN:    status = 2'b10;
      default:   status = 2'b00;
    endcase
  end

  assign core_reset = core_reset_q;
  assign ce_pix     = ce_pix_q;
  assign ce_pix_n   = ce_pix_n_q;

`ifndef SYNTHESIS
  a_ce_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ce_pix_q && ce_pix_n_q));
  a_ce_quiet_in_reset: assert property (@(posedge clk) disable iff (rst)
    core_reset_q |-> (!ce_pix_q && !ce_pix_n_q));
  a_reset_tracks_state: assert property (@(posedge clk) disable iff (rst)
    core_reset_q == (state_q != ST_RUN));
  a_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CNT_LAST);
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: directed scenarios plus randomized
// lock/request/reset stimulus scored against a timeline-based reference model.
module tb_pll_reset_seq;

  localparam int S = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       ext_reset_req;
  logic       core_reset;
  logic       ce_pix;
  logic       ce_pix_n;
  logic [1:0] status;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: inputs reach the sequencer two edges late; the most
  // recent "qualification start" edge decides everything else.
  bit lk_d1, lk_d2, ex_d1, ex_d2;
  bit m_wait, m_run;
  int edge_n  = 0;
  int m_start = 0;
  int m_div   = 0;
  int m_status = 0;

  pll_reset_seq #(.STABLE_CYCLES(S), .CE_DIV(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .ext_reset_req (ext_reset_req),
    .core_reset    (core_reset),
    .ce_pix        (ce_pix),
    .ce_pix_n      (ce_pix_n),
    .status        (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    lk_d1 = 0; lk_d2 = 0; ex_d1 = 0; ex_d2 = 0;
    m_wait = 1; m_run = 0; m_div = 0; m_status = 0;
  endtask

  task automatic model_edge();
    bit l, e;
    l = lk_d2;
    e = ex_d2;
    lk_d2 = lk_d1; lk_d1 = pll_locked;
    ex_d2 = ex_d1; ex_d1 = ext_reset_req;
    edge_n++;
    if (!l) begin
      m_wait = 1;
      m_run  = 0;
    end else begin
      if (m_wait || e) begin
        m_start = edge_n;
        m_wait  = 0;
      end
      m_run = (edge_n - m_start) >= S;
    end
    m_status = m_wait ? 0 : (m_run ? 2 : 1);
    m_div    = m_run ? (edge_n - m_start - S) % D : 0;
  endtask

  task automatic check_outputs();
    check("core_reset", core_reset, !m_run);
    check("status", status, m_status);
    check("ce_pix", ce_pix, m_run && (m_div == D - 1));
    check("ce_pix_n", ce_pix_n, m_run && (m_div == D / 2 - 1));
  endtask

  // One clock: drive inputs well before the edge, score just after it.
  task automatic cycle(input bit lk, input bit ex);
    pll_locked    = lk;
    ext_reset_req = ex;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_core_reset", core_reset, 1);
    check("rst_ce_pix", ce_pix, 0);
    check("rst_ce_pix_n", ce_pix_n, 0);
    check("rst_status", status, 0);
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs up to 'budget' cycles with the given inputs; returns the cycle index
  // at which core_reset was first seen low, or 0 if it never was.
  task automatic run_until_release(input bit ex, input int budget, output int idx);
    idx = 0;
    for (int i = 1; i <= budget && idx == 0; i++) begin
      cycle(1'b1, ex);
      if (core_reset === 1'b0) idx = i;
    end
  endtask

  initial begin
    int idx;
    logic [15:0] pix_mask, pixn_mask;
    logic [3:0]  restart_mask;
    bit saw_release, saw_run, saw_stable;
    int drop_left, ext_left;

    rst = 1'b1;
    pll_locked = 1'b0;
    ext_reset_req = 1'b0;
    model_reset();
    #1;
    check("init_core_reset", core_reset, 1);
    check("init_status", status, 0);
    check("init_ce", {ce_pix, ce_pix_n}, 0);
    pll_locked = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Release with lock already present.
    run_until_release(1'b0, 40, idx);
    check("release_edge", idx, S + 3);

    // Pixel enable pattern over the first 16 RUN cycles.
    pix_mask  = '0;
    pixn_mask = '0;
    pix_mask[0]  = ce_pix;
    pixn_mask[0] = ce_pix_n;
    for (int i = 1; i < 16; i++) begin
      cycle(1'b1, 1'b0);
      pix_mask[i]  = ce_pix;
      pixn_mask[i] = ce_pix_n;
    end
    check("ce_pix_pattern", pix_mask, 16'h8888);
    check("ce_pix_n_pattern", pixn_mask, 16'h2222);
    check("ce_overlap", pix_mask & pixn_mask, 0);

    // One-cycle lock glitch while running.
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("glitch_still_run", core_reset, 0);
    cycle(1'b1, 1'b0);
    check("glitch_reset", core_reset, 1);
    check("glitch_ce", {ce_pix, ce_pix_n}, 0);
    run_until_release(1'b0, 40, idx);
    check("glitch_requal", idx, S + 1);

    // External request held for 20 cycles while running.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1);
      if (i >= 2) check("ext_status", status, 1);
    end
    run_until_release(1'b0, 40, idx);
    check("ext_release", idx, S + 2);
    restart_mask = '0;
    restart_mask[0] = ce_pix;
    for (int i = 1; i < 4; i++) begin
      cycle(1'b1, 1'b0);
      restart_mask[i] = ce_pix;
    end
    check("ext_div_restart", restart_mask, 4'b1000);

    // Reset in the middle of RUN restarts full qualification.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    do_reset(2);
    run_until_release(1'b0, 40, idx);
    check("rst_requal", idx, S + 3);

    // Lock toggling every 5 cycles never qualifies.
    do_reset(1);
    saw_release = 0; saw_run = 0; saw_stable = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(((i / 5) % 2) == 0, 1'b0);
      if (core_reset !== 1'b1) saw_release = 1;
      if (status == 2'b10) saw_run = 1;
      if (status == 2'b01) saw_stable = 1;
    end
    check("toggle_no_release", saw_release, 0);
    check("toggle_no_run", saw_run, 0);
    check("toggle_saw_stable", saw_stable, 1);

    // Lock loss and request arriving together in STABLE: lock loss wins.
    do_reset(1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check("tie_before", status, 1);
    cycle(1'b0, 1'b1);
    check("tie_lock_wins", status, 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);

    // Randomized lock drops, requests and resets.
    drop_left = 0;
    ext_left  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (drop_left == 0 && $urandom_range(39, 0) == 0) drop_left = $urandom_range(12, 1);
      if (ext_left == 0 && $urandom_range(49, 0) == 0) ext_left = $urandom_range(25, 1);
      if ($urandom_range(499, 0) == 0) do_reset($urandom_range(3, 1));
      cycle(drop_left == 0, ext_left != 0);
      if (drop_left > 0) drop_left--;
      if (ext_left > 0) ext_left--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4096, number of clk cycles lock must hold before core reset release (>=1).
REQ-002 The block SHALL have parameter CE_DIV, default 4, pixel clock-enable divide ratio (even, >=2; 23.367344 MHz / 4 = 5.841836 MHz).
REQ-003 The block SHALL have port clk, input, 1, system clock (23.367344 MHz PLL outclk_0).
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port pll_locked, input, 1, PLL locked, asynchronous to clk.
REQ-006 The block SHALL have port ext_reset_req, input, 1, core reset request from HPS/OSD, asynchronous.
REQ-007 The block SHALL have port core_reset, output, 1, synchronous active-high reset to game logic.
REQ-008 The block SHALL have port ce_pix, output, 1, one-cycle pixel clock enable, rate clk/CE_DIV.
REQ-009 The block SHALL have port ce_pix_n, output, 1, one-cycle enable offset half a period from ce_pix.
REQ-010 The block SHALL have port status, output, 2, state code: 00 WAIT_LOCK, 01 STABLE, 10 RUN.

Function
REQ-011 pll_locked and ext_reset_req SHALL each pass a 2-flop synchronizer (locked_s, ext_s); 2-edge latency, no other filtering.
REQ-012 State machine SHALL have exactly three states: WAIT_LOCK, STABLE, RUN; code 11 unreachable, decoded as WAIT_LOCK.
REQ-013 WAIT_LOCK: stable counter held 0; locked_s=1 -> STABLE on next edge, counter 0.
REQ-014 STABLE: counter +1 per cycle; locked_s=0 -> WAIT_LOCK; else ext_s=1 -> counter cleared to 0, stay STABLE; else counter==STABLE_CYCLES-1 -> RUN.
REQ-015 Priority in every state SHALL be: locked_s=0 over ext_s=1 over counter terminal.
REQ-016 RUN: locked_s=0 -> WAIT_LOCK; else ext_s=1 -> STABLE with counter 0; else stay.
REQ-017 Stable counter width SHALL be clog2(STABLE_CYCLES)+1 bits; counter SHALL never wrap.
REQ-018 core_reset SHALL be a flop, low exactly when state==RUN, high in every cycle state!=RUN.
REQ-019 core_reset SHALL fall on the (3+STABLE_CYCLES)-th rising edge after pll_locked rises, given pll_locked meets setup and ext_reset_req=0.
REQ-020 Divider counter div (clog2(CE_DIV) bits) SHALL be 0 whenever state!=RUN, and count 0..CE_DIV-1 modulo CE_DIV in RUN starting at 0 in first RUN cycle.
REQ-021 ce_pix SHALL be high exactly in RUN cycles with div==CE_DIV-1; ce_pix_n exactly in RUN cycles with div==CE_DIV/2-1.
REQ-022 ce_pix and ce_pix_n SHALL never be high simultaneously, and SHALL both be low in any cycle core_reset is high.
REQ-023 Leaving RUN SHALL force ce_pix/ce_pix_n low in the same cycle core_reset rises; no truncated or extra pulse.
REQ-024 status SHALL reflect the current state register with no added latency.

Reset
REQ-025 rst=1 SHALL asynchronously set state WAIT_LOCK, core_reset=1, ce_pix=0, ce_pix_n=0, status=00, counters 0, synchronizer flops 0.
REQ-026 rst deassertion SHALL be synchronous in effect: first state change no earlier than 3 edges after rst falls.
REQ-027 rst asserted mid-STABLE or mid-RUN SHALL restart the full STABLE_CYCLES qualification after release.

Verification (STABLE_CYCLES=8, CE_DIV=4)
REQ-028 rst pulse, pll_locked=1 steady -> core_reset falls on edge 11 after rst release, status 00->01->10.
REQ-029 RUN, 16 cycles -> ce_pix pulses at RUN cycles 3,7,11,15; ce_pix_n at 1,5,9,13; never coincident.
REQ-030 pll_locked drops for 1 cycle in RUN -> core_reset high 2 edges later, ce outputs low, full 8-cycle requalification, then RUN.
REQ-031 pll_locked toggles every 5 cycles -> core_reset never deasserts, status alternates 00/01 only.
REQ-032 ext_reset_req high 20 cycles in RUN -> status 01, core_reset high throughout plus 8 cycles after ext_s falls, then RUN with div restarting at 0.
REQ-033 pll_locked falls same cycle ext_s rises in STABLE -> status 00 next cycle (lock loss wins).
